// File: rtl/fp16_mul_normround.sv
// fp16_mul_normround: normalize/round back end of the FP16 multiplier.
// Stage 1 normalizes the 13-bit mantissa product and rebiases the exponent.
// Stage 2 applies round-to-nearest-even, packs binary16 and raises of/uf/nx.
// Both stages form a valid/ready pipeline that buffers at most two beats.
// Subnormal results are flushed to zero.
// Build option: define FP16_MUL_SAT_EN to saturate finite overflow to
// +/-max finite (7BFF) instead of producing +/-inf.

module fp16_mul_normround #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int BIAS   = 15
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W:0]   in_exp_sum,
  input  logic [1:0]       in_class,
  input  logic [12:0]      in_mant,
  input  logic             in_ovf,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_of,
  output logic             out_uf,
  output logic             out_nx
);

  localparam logic [1:0] CLS_FINITE = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [7:0] BIAS8      = 8'(BIAS);
  localparam logic [7:0] EXP_MAX    = 8'd31;

  // stage 1 registers
  logic              s1_valid;
  logic              s1_sign;
  logic [1:0]        s1_class;
  logic [7:0]        s1_exp;      // two's complement, -13..46
  logic [FRAC_W-1:0] s1_frac;
  logic              s1_guard;
  logic              s1_sticky;

  logic              s2_valid;
  logic              s2_adv;

  // stage 1 next-state values
  logic [FRAC_W-1:0] n_frac;
  logic              n_guard;
  logic              n_sticky;
  logic [7:0]        n_exp;

  // stage 2 next-state values
  logic              round_up;
  logic [FRAC_W:0]   frac_inc;
  logic [7:0]        exp_rnd;
  logic              exp_le0;
  logic [15:0]       r_result;
  logic              r_of;
  logic              r_uf;
  logic              r_nx;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = nRST && (!s1_valid || s2_adv);
  assign out_valid = s2_valid;

  // Normalize: a set overflow bit means the product is in [2,4), shift one more.
  always_comb begin
    n_frac   = in_mant[11:2];
    n_guard  = in_mant[1];
    n_sticky = in_mant[0] | in_sticky;
    if (in_ovf) begin
      n_frac   = in_mant[12:3];
      n_guard  = in_mant[2];
      n_sticky = in_mant[1] | in_mant[0] | in_sticky;
    end
    n_exp = 8'(in_exp_sum) + {7'b0, in_ovf} - BIAS8;
  end

  // Round to nearest even, then classify and pack the binary16 result.
  always_comb begin
    round_up = s1_guard & (s1_sticky | s1_frac[0]);
    frac_inc = {1'b0, s1_frac} + {{FRAC_W{1'b0}}, round_up};
    // carry-out leaves the low fraction bits at zero, so only the exponent moves
    exp_rnd  = s1_exp + {7'b0, frac_inc[FRAC_W]};
    exp_le0  = s1_exp[7] || (s1_exp == 8'd0);
    r_result = 16'h0000;
    r_of     = 1'b0;
    r_uf     = 1'b0;
    r_nx     = 1'b0;
    case (s1_class)
      CLS_FINITE: begin
        if (exp_le0) begin
          r_result = {s1_sign, 15'h0000};
          r_uf     = 1'b1;
          r_nx     = 1'b1;
        end else if (exp_rnd >= EXP_MAX) begin
`ifdef FP16_MUL_SAT_EN
          r_result = {s1_sign, 15'h7BFF};
`else
          r_result = {s1_sign, 15'h7C00};
`endif
          r_of     = 1'b1;
          r_nx     = 1'b1;
        end else begin
          r_result = {s1_sign, exp_rnd[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
          r_nx     = s1_guard | s1_sticky;
        end
      end
      CLS_ZERO: r_result = {s1_sign, 15'h0000};
      CLS_INF:  r_result = {s1_sign, 15'h7C00};
      default:  r_result = 16'h7E00;
    endcase
  end

  // Stage 1: capture a normalized beat whenever the stage is empty or draining.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_class  <= 2'b00;
      s1_exp    <= 8'd0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (!s1_valid || s2_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= in_sign;
        s1_class  <= in_class;
        s1_exp    <= n_exp;
        s1_frac   <= n_frac;
        s1_guard  <= n_guard;
        s1_sticky <= n_sticky;
      end
    end
  end

  // Stage 2: register the packed result; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      s2_valid   <= 1'b0;
      out_result <= 16'h0000;
      out_of     <= 1'b0;
      out_uf     <= 1'b0;
      out_nx     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= r_result;
        out_of     <= r_of;
        out_uf     <= r_uf;
        out_nx     <= r_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_normround.sv
// Scoreboard bench for fp16_mul_normround: directed vectors with hand-computed
// binary16 results; expected responses are queued at accept time and a
// monitor compares them as the DUT hands results over.

module tb_fp16_mul_normround;

  logic        clk = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp_sum;
  logic [1:0]  in_class;
  logic [12:0] in_mant;
  logic        in_ovf;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_of;
  logic        out_uf;
  logic        out_nx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        of_f;
    logic        uf_f;
    logic        nx_f;
  } exp_t;

  typedef struct {
    logic        sign;
    logic [5:0]  es;
    logic [1:0]  cls;
    logic [12:0] mant;
    logic        ovf;
    logic        st;
    exp_t        e;
  } vec_t;

`ifdef FP16_MUL_SAT_EN
  localparam logic [15:0] OVF_RES = 16'h7BFF;
`else
  localparam logic [15:0] OVF_RES = 16'h7C00;
`endif

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb[$];

  fp16_mul_normround dut (
    .clk        (clk),
    .nRST       (nRST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_class   (in_class),
    .in_mant    (in_mant),
    .in_ovf     (in_ovf),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_of     (out_of),
    .out_uf     (out_uf),
    .out_nx     (out_nx)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic [5:0] es, logic [1:0] c, logic [12:0] m,
                              logic o, logic st, logic [15:0] r,
                              logic fo, logic fu, logic fx);
    vec_t v;
    v.sign = s; v.es = es; v.cls = c; v.mant = m; v.ovf = o; v.st = st;
    v.e.res = r; v.e.of_f = fo; v.e.uf_f = fu; v.e.nx_f = fx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one beat (caller sits just after a rising edge); returns just after
  // the accepting edge. waits counts cycles spent with in_ready low.
  task automatic send(input int idx, input bit push, output int waits);
    bit done;
    in_valid   = 1'b1;
    in_sign    = vecs[idx].sign;
    in_exp_sum = vecs[idx].es;
    in_class   = vecs[idx].cls;
    in_mant    = vecs[idx].mant;
    in_ovf     = vecs[idx].ovf;
    in_sticky  = vecs[idx].st;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(vecs[idx].e);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout actual=in_ready_low required=accept idx=%0d", idx);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every handed-over result must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (nRST && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", out_result);
      end else begin
        e = sb.pop_front();
        if ({out_result, out_of, out_uf, out_nx} !== e) begin
          errors++;
          $display("FAIL result actual=%h of=%b uf=%b nx=%b required=%h of=%b uf=%b nx=%b",
                   out_result, out_of, out_uf, out_nx, e.res, e.of_f, e.uf_f, e.nx_f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int bp[5];
    // sign, exp_sum, class, mant, ovf, sticky -> result, of, uf, nx
    vecs[0]  = mk(0, 30, 2'b00, 13'h0400, 1, 0, 16'h4080, 0, 0, 0); // 1.5*1.5
    vecs[1]  = mk(0, 30, 2'b00, 13'h1002, 0, 0, 16'h3C00, 0, 0, 1); // tie, even stays
    vecs[2]  = mk(0, 30, 2'b00, 13'h1006, 0, 0, 16'h3C02, 0, 0, 1); // tie, odd rounds up
    vecs[3]  = mk(0, 30, 2'b00, 13'h1002, 0, 1, 16'h3C01, 0, 0, 1); // above half
    vecs[4]  = mk(0, 45, 2'b00, 13'h1FFE, 0, 0, OVF_RES,  1, 0, 1); // round carry to exp 31
    vecs[5]  = mk(1, 10, 2'b00, 13'h1000, 0, 0, 16'h8000, 0, 1, 1); // underflow
    vecs[6]  = mk(1, 30, 2'b11, 13'h1234, 1, 1, 16'h7E00, 0, 0, 0); // NaN
    vecs[7]  = mk(1, 30, 2'b10, 13'h0000, 0, 0, 16'hFC00, 0, 0, 0); // -inf
    vecs[8]  = mk(1, 30, 2'b01, 13'h1FFF, 0, 1, 16'h8000, 0, 0, 0); // -0 class
    vecs[9]  = mk(0, 16, 2'b00, 13'h1000, 0, 0, 16'h0400, 0, 0, 0); // exp = 1, min normal
    vecs[10] = mk(0, 15, 2'b00, 13'h1000, 0, 0, 16'h0000, 0, 1, 1); // exp = 0, flushed
    vecs[11] = mk(0, 45, 2'b00, 13'h1FF8, 0, 0, 16'h7BFE, 0, 0, 0); // exp 30, no round
    vecs[12] = mk(0, 30, 2'b00, 13'h1FFF, 1, 1, 16'h4400, 0, 0, 1); // ovf path round carry
    bp[0] = 1; bp[1] = 2; bp[2] = 3; bp[3] = 9; bp[4] = 11;

    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp_sum = '0; in_class = '0; in_mant = '0; in_ovf = 1'b0; in_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", {12'd0, out_result, out_of, out_uf, out_nx}, 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // latency: empty pipe, accept -> out_valid two edges later
    send(0, 1'b1, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    idle_cycles(3);

    // directed vectors, back-to-back at full throughput
    for (int i = 1; i < NV; i++) begin
      send(i, 1'b1, w);
      chk("stream_no_wait", 32'(w), 32'd0);
    end
    idle_cycles(5);

    // backpressure: consumer stalled, two beats fill the pipe
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      send(bp[j], 1'b1, w);
      chk("bp_accept_no_wait", 32'(w), 32'd0);
    end
    in_valid   = 1'b1;
    in_sign    = vecs[bp[2]].sign;
    in_exp_sum = vecs[bp[2]].es;
    in_class   = vecs[bp[2]].cls;
    in_mant    = vecs[bp[2]].mant;
    in_ovf     = vecs[bp[2]].ovf;
    in_sticky  = vecs[bp[2]].st;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", {13'd0, out_result, out_nx, out_of, out_uf},
          {13'd0, vecs[bp[0]].e.res, vecs[bp[0]].e.nx_f, 2'b00});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int j = 2; j < 5; j++) begin
      send(bp[j], 1'b1, w);
      chk("bp_release_no_wait", 32'(w), 32'd0);
    end
    idle_cycles(6);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(4, 1'b0, w);
    send(7, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    nRST = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_bits", {12'd0, out_result, out_of, out_uf, out_nx}, 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle_cycles(6);

    // pipe still works after the mid-stream reset
    send(12, 1'b1, w);
    idle_cycles(5);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
